key_led_ctrl: RTL
=================

KEY_LED_CTRL -- requirements
Module: key_led_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable samples before a key change is accepted; minimum 2.
REQ-002 Parameter STEP_CYCLES, default 12500000, clock cycles per pattern step in slow speed; even, minimum 4.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port key  input  4  raw push-buttons, asynchronous, active-low (0 = pressed).
REQ-006 Port led  output 4  registered LED drive, active-high.
REQ-007 Port mode output 2  registered current display mode.

Function
REQ-008 Each key bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-009 Each key SHALL have an independent debouncer: the counter clears whenever the synced sample equals the debounced state, and increments otherwise.
REQ-010 When the counter reaches DEBOUNCE_CYCLES, the debounced state SHALL take the synced value and the counter SHALL clear in the same cycle.
REQ-011 A press event SHALL be a one-cycle pulse on the cycle the debounced state goes released->pressed; releases generate no event.
REQ-012 Mode encoding: 00 DIRECT, 01 RUN, 10 BLINK, 11 COUNT.
REQ-013 key[0] press SHALL advance mode +1, wrapping 11->00; key[1] press SHALL step mode -1, wrapping 00->11.
REQ-014 Simultaneous key[0] and key[1] press events SHALL be resolved in favour of key[0].
REQ-015 key[2] press SHALL toggle speed; slow = STEP_CYCLES cycles per step, fast = STEP_CYCLES/2.
REQ-016 key[3] press SHALL toggle pause; key[2] and key[3] events SHALL act in the same cycle as, and independently of, mode events.
REQ-017 Prescaler: counts 0..(period-1); it SHALL emit a one-cycle tick on wrap to 0.
REQ-018 While paused, the prescaler and pattern SHALL hold their values.
REQ-019 A speed change SHALL clear the prescaler.
REQ-020 On any mode change, the prescaler SHALL clear and the pattern SHALL load the new mode's initial value: RUN 0001, BLINK 0000, COUNT 0000.
REQ-021 DIRECT: led SHALL equal the inverted debounced key state (1 = pressed); pause and tick are ignored.
REQ-022 RUN: each tick SHALL rotate the pattern left, 0001->0010->0100->1000->0001.
REQ-023 BLINK: each tick SHALL toggle the pattern between 0000 and 1111.
REQ-024 COUNT: each tick SHALL increment the pattern as 4-bit unsigned, wrapping 1111->0000.
REQ-025 led SHALL be registered one cycle after the pattern/debounced state.
REQ-026 In DIRECT mode, led SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after a clean key transition.
REQ-027 mode SHALL update on the cycle after the press event.
REQ-028 Key chatter shorter than DEBOUNCE_CYCLES SHALL produce no state change or event.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL load the following values: led=0000, mode=00, speed=slow, pause=0, pattern=0000, all counters 0, synchronizer and debounced states=1111 (released).
REQ-030 Reset asserted mid-operation (mid-debounce, mid-step, paused) SHALL override all other activity with no residual event after release.
REQ-031 A key held through the reset release SHALL generate a press event only after debounce completes; no event is lost or duplicated.

Verification (sim with DEBOUNCE_CYCLES=4, STEP_CYCLES=8)
REQ-032 Reset, then key=1110 held: led=0001 exactly 7 edges after the change; led=0000 7 edges after release.
REQ-033 key[0] pulsed low for 3 cycles: no mode change; held for 10 cycles: mode=01, led sequence 0001,0010,0100,1000,0001 every 8 cycles.
REQ-034 In RUN, press key[2]: step period 4 cycles; press key[3]: led frozen for 40 cycles; press key[3] again: rotation resumes from the frozen value.
REQ-035 key[0] and key[1] pressed in the same cycle at mode=11: mode=00 (wrap, key[0] wins); at mode=00, key[1] alone gives mode=11 and COUNT 0000->0001 ... 1111->0000.
REQ-036 Assert rst during COUNT at 0101 while paused and fast: led=0000, mode=00, speed slow, unpaused on the next cycle.

Source files
------------

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: four debounced keys driving a 4-bit LED display
// with DIRECT/RUN/BLINK/COUNT modes, speed and pause control.
module key_led_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [3:0] led,
  output logic [1:0] mode
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] SLOW_LAST =
    PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] FAST_LAST =
    PW'(STEP_CYCLES / 2 - 1);

  typedef enum logic [1:0] {
    M_DIRECT = 2'b00,
    M_RUN    = 2'b01,
    M_BLINK  = 2'b10,
    M_COUNT  = 2'b11
  } mode_e;

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [3:0]    press;
  logic [DW-1:0] cnt [4];

  mode_e         mode_q;
  mode_e         mode_d;
  logic          mode_chg;
  logic          fast;
  logic          paused;
  logic          tick;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_last;
  logic [3:0]    pat;
  logic [3:0]    pat_step;
  logic [3:0]    pat_init;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // press pulses with the debounced level falling to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      deb   <= 4'hF;
      press <= 4'h0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]   <= '0;
          deb[i]   <= sync2[i];
          press[i] <= deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mode_q <= M_DIRECT;
    else     mode_q <= mode_d;
  end

  // key[0] wins over key[1] when both fire together
  always_comb begin
    mode_d   = mode_q;
    mode_chg = 1'b0;
    if (press[0]) begin
      mode_d   = mode_e'(mode_q + 2'd1);
      mode_chg = 1'b1;
    end else if (press[1]) begin
      mode_d   = mode_e'(mode_q - 2'd1);
      mode_chg = 1'b1;
    end
  end

  always_comb begin
    presc_last = fast ? FAST_LAST : SLOW_LAST;
    tick       = !paused && (presc == presc_last);
    pat_init   = (mode_d == M_RUN) ? 4'b0001 : 4'b0000;
    pat_step   = pat;
    unique case (mode_q)
      M_RUN:    pat_step = {pat[2:0], pat[3]};
      M_BLINK:  pat_step = ~pat;
      M_COUNT:  pat_step = pat + 4'd1;
      M_DIRECT: pat_step = pat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fast   <= 1'b0;
      paused <= 1'b0;
      presc  <= '0;
      pat    <= 4'h0;
    end else begin
      if (press[2]) fast   <= ~fast;
      if (press[3]) paused <= ~paused;
      if (mode_chg) begin
        presc <= '0;
        pat   <= pat_init;
      end else if (press[2]) begin
        presc <= '0;
      end else if (tick) begin
        presc <= '0;
        pat   <= pat_step;
      end else if (!paused) begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    led <= 4'h0;
    else if (mode_q == M_DIRECT) led <= ~deb;
    else                        led <= pat;
  end

  assign mode = mode_q;

endmodule
